// File: rtl/preemph_framer.sv
// rtl/preemph_framer.sv - frames a sample RAM into overlapping windows and applies 31/32 pre-emphasis.
module preemph_framer #(
    parameter int FRAME_LEN  = 256,
    parameter int HOP        = 128,
    parameter int NUM_FRAMES = 96
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [14:0]        ram_addr,
    input  logic signed [15:0] ram_data,
    output logic signed [15:0] sample_out,
    output logic               sample_valid,
    input  logic               sample_ready,
    output logic               frame_first,
    output logic               frame_last,
    output logic               busy,
    output logic               done
);
    localparam int IW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int FW = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_PRIME, S_PWAIT, S_READ, S_RWAIT, S_OUT, S_DONE
    } state_t;

    state_t              state, next_state;
    logic [IW-1:0]       idx;
    logic [FW-1:0]       frame;
    logic [14:0]         base;
    logic signed [15:0]  x_prev, x_cur;
    logic signed [17:0]  xe, pe, y;
    logic signed [15:0]  y_sat;
    logic                handshake, last_idx, last_frame;

    assign handshake  = (state == S_OUT) && sample_ready;
    assign last_idx   = (idx == IW'(FRAME_LEN - 1));
    assign last_frame = (frame == FW'(NUM_FRAMES - 1));

    assign sample_valid = (state == S_OUT);
    assign frame_first  = (state == S_OUT) && (idx == '0);
    assign frame_last   = (state == S_OUT) && last_idx;
    assign busy         = (state != S_IDLE) && (state != S_DONE);
    assign done         = (state == S_DONE);

    // 18-bit headroom covers the full x - x_prev swing plus the 1/32 term before clamping.
    always_comb begin
        xe = {{2{ram_data[15]}}, ram_data};
        pe = {{2{x_prev[15]}}, x_prev};
        y  = xe - pe + (pe >>> 5);
        if (y > 18'sd32767)
            y_sat = 16'sh7fff;
        else if (y < -18'sd32768)
            y_sat = 16'sh8000;
        else
            y_sat = y[15:0];
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE, S_DONE: if (start) next_state = S_READ;
            S_PRIME:        next_state = S_PWAIT;
            S_PWAIT:        next_state = S_READ;
            S_READ:         next_state = S_RWAIT;
            S_RWAIT:        next_state = S_OUT;
            S_OUT: begin
                if (handshake) begin
                    if (!last_idx)
                        next_state = S_READ;
                    else if (last_frame)
                        next_state = S_DONE;
                    else
                        next_state = S_PRIME;
                end
            end
            default:        next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ram_addr   <= '0;
            sample_out <= '0;
            idx        <= '0;
            frame      <= '0;
            base       <= '0;
            x_prev     <= '0;
            x_cur      <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        idx    <= '0;
                        frame  <= '0;
                        base   <= '0;
                        x_prev <= '0;
                    end
                end
                // Later frames re-read the sample just before the window so the filter has history.
                S_PRIME: ram_addr <= base - 15'd1;
                S_PWAIT: begin
                    x_prev <= ram_data;
                    idx    <= '0;
                end
                S_READ:  ram_addr <= base + 15'(idx);
                S_RWAIT: begin
                    x_cur      <= ram_data;
                    sample_out <= y_sat;
                end
                S_OUT: begin
                    if (handshake) begin
                        x_prev <= x_cur;
                        if (!last_idx) begin
                            idx <= idx + 1'b1;
                        end else if (!last_frame) begin
                            frame <= frame + 1'b1;
                            base  <= base + 15'(HOP);
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_preemph_framer.sv
// tb/tb_preemph_framer.sv - scoreboard bench for preemph_framer with FRAME_LEN=4, HOP=2, NUM_FRAMES=3.
module tb_preemph_framer;
    logic               clk = 1'b0;
    logic               rst, start, sample_ready;
    logic [14:0]        ram_addr;
    logic signed [15:0] ram_data, sample_out;
    logic               sample_valid, frame_first, frame_last, busy, done;

    logic signed [15:0] mem [0:7];
    int n_tests = 0, n_fail = 0, hs_count = 0, cyc = 0, max_addr = 0;
    int hs_cycles[$];

    typedef struct {
        logic signed [15:0] s;
        logic               f;
        logic               l;
        logic [14:0]        a;
    } exp_t;
    exp_t q[$];

    preemph_framer #(.FRAME_LEN(4), .HOP(2), .NUM_FRAMES(3)) dut (
        .clk(clk), .rst(rst), .start(start), .ram_addr(ram_addr), .ram_data(ram_data),
        .sample_out(sample_out), .sample_valid(sample_valid), .sample_ready(sample_ready),
        .frame_first(frame_first), .frame_last(frame_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    assign ram_data = mem[ram_addr[2:0]];
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: a handshake seen here completes on the following rising edge.
    always @(negedge clk) begin
        if (int'(ram_addr) > max_addr) max_addr = int'(ram_addr);
        if (!rst && sample_valid && sample_ready) begin
            hs_cycles.push_back(cyc);
            hs_count++;
            n_tests++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_sample: got %0d with nothing expected", sample_out);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (sample_out !== e.s || frame_first !== e.f || frame_last !== e.l || ram_addr !== e.a) begin
                    n_fail++;
                    $display("FAIL sample: got s=%0d f=%0b l=%0b a=%0d expected s=%0d f=%0b l=%0b a=%0d",
                             sample_out, frame_first, frame_last, ram_addr, e.s, e.f, e.l, e.a);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int v[8]);
        for (int i = 0; i < 8; i++) mem[i] = 16'(v[i]);
    endtask

    task automatic push_run(input int v[12], input int n);
        for (int i = 0; i < n; i++) begin
            exp_t e;
            e.s = 16'(v[i]);
            e.f = (i % 4 == 0);
            e.l = (i % 4 == 3);
            e.a = 15'((i / 4) * 2 + i % 4);
            q.push_back(e);
        end
    endtask

    task automatic pulse_start_latency;
        int lat;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            lat++;
            if (sample_valid) break;
        end
        chk("first_valid_latency", lat, 3);
    endtask

    task automatic wait_done;
        int k;
        for (k = 0; k < 300; k++) begin
            tick();
            if (done) break;
        end
        chk("done_reached", int'(done), 1);
        chk("busy_after_done", int'(busy), 0);
    endtask

    task automatic wait_hs(input int target);
        int k;
        for (k = 0; k < 200; k++) begin
            if (hs_count == target) break;
            tick();
        end
        chk("reach_handshake", hs_count, target);
    endtask

    task automatic wait_valid;
        int k;
        for (k = 0; k < 50; k++) begin
            @(negedge clk);
            if (sample_valid) break;
        end
        chk("valid_seen", int'(sample_valid), 1);
    endtask

    initial begin
        int v_flat[8]  = '{1024, 1024, 1024, 1024, 1024, 1024, 1024, 1024};
        int e_flat[12] = '{1024, 32, 32, 32, 32, 32, 32, 32, 32, 32, 32, 32};
        int v_sat[8]   = '{32767, -32768, 32767, 0, 100, 200, -64, 1000};
        int e_sat[12]  = '{32767, -32768, 32767, -31744, 32767, -31744, 100, 103, 100, 103, -258, 1062};
        int v_rst[8]   = '{1000, 2000, -500, 0, 64, 32, 0, 0};
        int e_rst[12]  = '{1000, 1031, -2438, 484, -2438, 484, 64, -30, 64, -30, -31, 0};
        int hs0;
        logic [34:0] held;

        rst = 1'b1; start = 1'b1; sample_ready = 1'b0;
        load(v_flat);
        repeat (3) tick();
        chk("reset_ram_addr", int'(ram_addr), 0);
        chk("reset_sample_out", sample_out, 0);
        chk("reset_flags", int'({sample_valid, frame_first, frame_last, busy, done}), 0);
        rst = 1'b0; start = 1'b0;
        tick();
        chk("rst_overrides_start", int'({busy, sample_valid}), 0);

        // Run 1: flat RAM, ready held high, check throughput spacing.
        sample_ready = 1'b1;
        hs_cycles.delete();
        hs0 = hs_count;
        push_run(e_flat, 12);
        pulse_start_latency();
        wait_done();
        chk("run1_handshakes", hs_count - hs0, 12);
        if (hs_cycles.size() >= 5) begin
            chk("gap_within_frame", hs_cycles[1] - hs_cycles[0], 3);
            chk("gap_frame_boundary", hs_cycles[4] - hs_cycles[3], 5);
        end else begin
            chk("gap_samples_present", hs_cycles.size(), 12);
        end
        chk("run1_queue_empty", q.size(), 0);

        // Run 2: saturation vectors, restarted from DONE, with a 5-cycle stall.
        load(v_sat);
        hs0 = hs_count;
        push_run(e_sat, 12);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_hs(hs0 + 2);
        sample_ready = 1'b0;
        wait_valid();
        held = {sample_out, frame_first, frame_last, sample_valid, ram_addr};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_stable", int'({sample_out, frame_first, frame_last, sample_valid, ram_addr} == held), 1);
        end
        tick();
        sample_ready = 1'b1;
        wait_done();
        chk("run2_handshakes", hs_count - hs0, 12);
        chk("run2_queue_empty", q.size(), 0);

        // Run 3: reset while presenting frame 1 sample 1, then restart.
        load(v_rst);
        hs0 = hs_count;
        push_run(e_rst, 5);
        pulse_start_latency();
        wait_hs(hs0 + 5);
        sample_ready = 1'b0;
        wait_valid();
        rst = 1'b1;
        tick();
        chk("midrun_reset_ram_addr", int'(ram_addr), 0);
        chk("midrun_reset_sample_out", sample_out, 0);
        chk("midrun_reset_flags", int'({sample_valid, frame_first, frame_last, busy, done}), 0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("idle_after_reset", int'({sample_valid, busy}), 0);
        end
        chk("run3a_queue_empty", q.size(), 0);
        sample_ready = 1'b1;
        hs0 = hs_count;
        push_run(e_rst, 12);
        pulse_start_latency();
        wait_done();
        chk("run3_handshakes", hs_count - hs0, 12);
        chk("run3_queue_empty", q.size(), 0);
        chk("max_ram_addr", max_addr, 7);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/preemph_framer.md
PREEMPH_FRAMER -- requirements
Module: preemph_framer

Interface
REQ-001 Parameter FRAME_LEN, default 256, samples per frame (power of two, 4..1024).
REQ-002 Parameter HOP, default 128, address step between frame starts (1..FRAME_LEN).
REQ-003 Parameter NUM_FRAMES, default 96, frames per utterance; (NUM_FRAMES-1)*HOP+FRAME_LEN SHALL be <= 32768.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous and active-high.
REQ-006 start  in  1  begin one utterance pass; sampled only in IDLE or DONE.
REQ-007 ram_addr  out  15  sample RAM read address, registered.
REQ-008 ram_data  in  16  signed sample from RAM, valid one cycle after ram_addr is presented.
REQ-009 sample_out  out  16  signed pre-emphasised sample, registered.
REQ-010 sample_valid  out  1  sample_out is valid.
REQ-011 sample_ready  in  1  downstream accepts sample_out this cycle.
REQ-012 frame_first  out  1  qualifies sample_out as sample 0 of a frame.
REQ-013 frame_last  out  1  qualifies sample_out as sample FRAME_LEN-1 of a frame.
REQ-014 busy  out  1  high in every state except IDLE and DONE.
REQ-015 done  out  1  high while in DONE.

Function
REQ-016 FSM states: IDLE, PRIME, PWAIT, READ, RWAIT, OUT, DONE.
REQ-017 IDLE/DONE + start: frame=0, idx=0, base=0, x_prev=0, go to READ (frame 0 skips PRIME).
REQ-018 PRIME: ram_addr=base-1; next PWAIT. PWAIT: x_prev<=ram_data; idx=0; next READ.
REQ-019 READ: ram_addr=base+idx; next RWAIT. RWAIT: capture ram_data as x, compute y, load sample_out; next OUT.
REQ-020 Pre-emphasis: y = x - x_prev + (x_prev >>> 5) (coefficient 31/32), in 18-bit signed; saturate to [-32768, 32767].
REQ-021 OUT: sample_valid=1; sample_out, frame_first, frame_last held stable until the sample_valid&&sample_ready cycle.
REQ-022 On handshake: x_prev<=x; if idx<FRAME_LEN-1: idx++, go READ.
REQ-023 On handshake with idx==FRAME_LEN-1: if frame==NUM_FRAMES-1 go DONE, else frame++, base+=HOP, go PRIME.
REQ-024 Latency: first sample_valid 3 cycles after start sampled; with sample_ready held high, one sample per 3 cycles within a frame, 5 cycles across a frame boundary.
REQ-025 frame_first = (idx==0) in OUT; frame_last = (idx==FRAME_LEN-1) in OUT; both 0 when sample_valid=0.
REQ-026 start ignored while busy; start in DONE restarts immediately per REQ-017.
REQ-027 ram_addr never exceeds (NUM_FRAMES-1)*HOP+FRAME_LEN-1; no arithmetic wrap permitted.
REQ-028 sample_ready while sample_valid=0 has no effect.

Reset
REQ-029 rst high at any edge, including mid-frame or in OUT: state=IDLE, ram_addr=0, sample_out=0, sample_valid=0, frame_first=0, frame_last=0, busy=0, done=0, x_prev=0, counters 0.
REQ-030 rst overrides start in the same cycle; after reset release, no output until a new start.

Verification
REQ-031 FRAME_LEN=4, HOP=2, NUM_FRAMES=3, ready high -> ram_addr read sequence 0,1,2,3,1,2,3,4,5,3,4,5,6,7; 12 handshakes; done high after last.
REQ-032 Frame 0, RAM[0]=1000 -> first sample_out=1000 with frame_first=1, 3 cycles after start.
REQ-033 All RAM=1024 -> frame 0 sample 0 = 1024, every later sample = 32, including sample 0 of frames >=1 (primed x_prev).
REQ-034 x_prev=32767, x=-32768 -> sample_out=-32768 (saturated); x_prev=-32768, x=32767 -> 32767.
REQ-035 sample_ready low 5 cycles in OUT -> sample_out/flags stable, ram_addr unchanged, no skipped or duplicated sample.
REQ-036 rst asserted in OUT of frame 1 -> next cycle all outputs 0, state IDLE; start afterwards restarts at ram_addr 0.
